instruction_loader: RTL and testbench

Writer side of the instruction memory: assembles program words from a byte stream (UART receiver output) and writes them sequentially into the 64-word instruction memory that the fetch stage reads combinationally. Sits between the UART receiver and the instruction memory write port. Loading starts on command and ends on a halt word or a full memory. Completion is reported so the debug unit can release the CPU.

---
 rtl/instruction_loader.sv | 169 ++++++++++++++++
 tb/tb_instruction_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - assembles big-endian words from a byte stream and writes them to instruction memory
// Optional trailing checksum byte after the terminating write is enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_load_error
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  take_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  load_error_q, load_error_d;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        word_count_d = word_count_q;
        take_byte    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        load_error_d = load_error_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_load_start) begin
                    state_d      = S_RECV;
                    addr_d       = '0;
                    byte_cnt_d   = '0;
                    word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = '0;
                    load_error_d = 1'b0;
`endif
                end
            end
            S_RECV: take_byte = i_rx_valid;
            S_WRITE: begin
                // A byte arriving alongside the final write is dropped on purpose.
                if (mem_data_q == HALT_WORD || mem_addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d   = S_RECV;
                    addr_d    = addr_q + ADDR_ONE;
                    take_byte = i_rx_valid;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_rx_valid) begin
                    load_error_d = (i_rx_data != csum_q);
                    state_d      = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (take_byte) begin
            shift_d = {shift_q[15:0], i_rx_data};
`ifdef LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ i_rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
                state_d      = S_WRITE;
                mem_we_d     = 1'b1;
                mem_addr_d   = addr_q;
                mem_data_d   = {shift_q, i_rx_data};
                word_count_d = word_count_q + CNT_ONE;
                byte_cnt_d   = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end

        busy_d      = (state_d == S_RECV) || (state_d == S_WRITE);
        load_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
            load_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            load_error_q <= load_error_d;
`endif
        end
    end

    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_data   = mem_data_q;
    assign o_busy       = busy_q;
    assign o_load_done  = load_done_q;
    assign o_word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    assign o_load_error = load_error_q;
`else
    assign o_load_error = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized and directed bench for instruction_loader against a behavioural model
module tb_instruction_loader;
    localparam int          AW   = 6;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_load_start = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_rx_valid = 1'b0;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;
    logic          o_busy;
    logic          o_load_done;
    logic [AW:0]   o_word_count;
    logic          o_load_error;

    always #5 clk = ~clk;

    instruction_loader #(.ADDR_WIDTH(AW), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst(rst), .i_load_start(i_load_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_busy(o_busy), .o_load_done(o_load_done),
        .o_word_count(o_word_count), .o_load_error(o_load_error)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: a load is "active" while collecting bytes or presenting a write,
    // "checking" while waiting for the checksum byte, "done" once finished.
    bit          m_active, m_chk, m_done, m_err, m_we;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_csum;
    int          m_addr, m_count, m_waddr;
    logic [31:0] m_wdata;

    logic [31:0] dut_mem [0:63];
    int          dut_writes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit wrote, last;
        wrote = m_we;
        last  = m_we && (m_wdata == HALT || m_waddr == (1 << AW) - 1);
        m_we  = 1'b0;
        if (rst) begin
            m_active = 0; m_chk = 0; m_done = 0; m_err = 0;
            m_addr = 0; m_count = 0; m_waddr = 0; m_wdata = '0; m_csum = '0;
            m_bytes.delete();
        end else if (m_chk) begin
            if (i_rx_valid) begin
                m_err  = (i_rx_data != m_csum);
                m_chk  = 0;
                m_done = 1;
            end
        end else if (!m_active) begin
            if (i_load_start) begin
                m_active = 1; m_done = 0; m_err = 0;
                m_addr = 0; m_count = 0; m_csum = '0;
                m_bytes.delete();
            end
        end else if (last) begin
            m_active = 0;
            if (CSUM) m_chk = 1; else m_done = 1;
        end else begin
            if (wrote) m_addr++;
            if (i_rx_valid) begin
                m_bytes.push_back(i_rx_data);
                m_csum ^= i_rx_data;
                if (m_bytes.size() == 4) begin
                    m_we    = 1;
                    m_wdata = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_waddr = m_addr;
                    m_count++;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
        rst          = r;
        i_load_start = s;
        i_rx_valid   = v;
        i_rx_data    = v ? d : 8'($urandom);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int b = 3; b >= 0; b--) begin
            idle($urandom_range(max_gap, 0));
            step(0, 0, 1, w[b*8 +: 8]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_we", 64'(o_mem_we), 64'(m_we));
            if (m_we) begin
                check("mem_addr", 64'(o_mem_addr), 64'(m_waddr));
                check("mem_data", 64'(o_mem_data), 64'(m_wdata));
            end
            check("busy", 64'(o_busy), 64'(m_active));
            check("load_done", 64'(o_load_done), 64'(m_done));
            check("word_count", 64'(o_word_count), 64'(m_count));
            check("load_error", 64'(o_load_error), 64'(m_err));
            if (o_mem_we) begin
                dut_mem[o_mem_addr] = o_mem_data;
                dut_writes++;
            end
        end
    end

    initial begin
        // Reset with random activity on inputs
        step(1, 1'($urandom), 1'($urandom), 8'($urandom));
        chk_en = 1'b1;
        step(1, 1'($urandom), 1'($urandom), 8'($urandom));
        check("rst_outputs", {o_mem_we, o_busy, o_load_done, o_load_error}, 64'd0);
        check("rst_addr_data", {o_mem_addr, o_mem_data, o_word_count}, 64'd0);

        // Bytes before any start are ignored
        send_word(32'h12345678, 1);
        idle(2);
        check("pre_start_writes", 64'(dut_writes), 64'd0);

        // Basic load, back-to-back bytes across the WRITE cycle
        step(0, 1, 0, 8'h00);
        send_word(32'h20080005, 0);
        send_word(HALT, 0);
        if (CSUM) begin idle(1); step(0, 0, 1, 8'h2D); end
        idle(2);
        check("basic_w0", 64'(dut_mem[0]), 64'h20080005);
        check("basic_w1", 64'(dut_mem[1]), 64'hFFFFFFFF);
        check("basic_count", 64'(o_word_count), 64'd2);
        check("basic_done", 64'(o_load_done), 64'd1);
        check("basic_nwrites", 64'(dut_writes), 64'd2);

        // Start pulse inside a word is ignored
        dut_writes = 0;
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h22);
        step(0, 1, 1, 8'h33);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h44);
        send_word(HALT, 2);
        if (CSUM) step(0, 0, 1, 8'h44);
        idle(2);
        check("mid_start_w0", 64'(dut_mem[0]), 64'h11223344);
        check("mid_start_nwrites", 64'(dut_writes), 64'd2);

        // Reset in the middle of a word
        dut_writes = 0;
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'hAA);
        step(0, 0, 1, 8'hBB);
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        send_word(32'h01020304, 1);
        send_word(HALT, 1);
        if (CSUM) begin
            step(0, 0, 1, 8'h04);
            idle(1);
            check("csum_good", 64'(o_load_error), 64'd0);
        end
        idle(2);
        check("rst_mid_w0", 64'(dut_mem[0]), 64'h01020304);
        check("rst_mid_nwrites", 64'(dut_writes), 64'd2);
        if (CSUM) begin
            step(0, 1, 0, 8'h00);
            send_word(32'h01020304, 0);
            send_word(HALT, 0);
            step(0, 0, 1, 8'h05);
            idle(1);
            check("csum_bad", 64'(o_load_error), 64'd1);
        end

        // Full memory: 64 non-halt words, then extra bytes that must be ignored
        dut_writes = 0;
        step(0, 1, 0, 8'h00);
        for (int k = 0; k < 64; k++) send_word(32'(k), 1);
        send_word(32'hDEADBEEF, 1);
        idle(3);
        check("full_nwrites", 64'(dut_writes), 64'd64);
        check("full_count", 64'(o_word_count), 64'd64);
        check("full_done", 64'(o_load_done), 64'd1);
        check("full_w63", 64'(dut_mem[63]), 64'd63);

        // Random loads with stray starts, occasional resets and varied spacing
        for (int l = 0; l < 40; l++) begin
            int nw;
            nw = $urandom_range(8, 1);
            step(0, 1, 0, 8'h00);
            for (int w = 0; w < nw; w++) begin
                logic [31:0] word;
                word = (w == nw - 1) ? HALT : $urandom;
                for (int b = 3; b >= 0; b--) begin
                    int gap;
                    gap = $urandom_range(2, 0);
                    for (int g = 0; g < gap; g++)
                        step(($urandom_range(150, 0) == 0), ($urandom_range(7, 0) == 0), 0, 8'h00);
                    step(0, ($urandom_range(9, 0) == 0), 1, word[b*8 +: 8]);
                end
            end
            for (int t = 0; t < 3; t++)
                step(0, 0, 1'($urandom), 8'($urandom));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
